// File: rtl/axi_ram_wr_responder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// axi_ram_wr_responder: AXI4 write slave committing strobed bursts to a RAM
// Revision: 1.0
// ---------------------------------------------------------------------------
module axi_ram_wr_responder #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int ID_WIDTH   = 8
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic [ID_WIDTH-1:0]                         s_axi_awid,
  input  logic [ADDR_WIDTH-1:0]                       s_axi_awaddr,
  input  logic [7:0]                                  s_axi_awlen,
  input  logic [2:0]                                  s_axi_awsize,
  input  logic [1:0]                                  s_axi_awburst,
  input  logic                                        s_axi_awvalid,
  output logic                                        s_axi_awready,
  input  logic [DATA_WIDTH-1:0]                       s_axi_wdata,
  input  logic [STRB_WIDTH-1:0]                       s_axi_wstrb,
  input  logic                                        s_axi_wlast,
  input  logic                                        s_axi_wvalid,
  output logic                                        s_axi_wready,
  output logic [ID_WIDTH-1:0]                         s_axi_bid,
  output logic [1:0]                                  s_axi_bresp,
  output logic                                        s_axi_bvalid,
  input  logic                                        s_axi_bready,
  input  logic [ADDR_WIDTH-$clog2(STRB_WIDTH)-1:0]    dbg_addr,
  output logic [DATA_WIDTH-1:0]                       dbg_rdata
);

  localparam int         c_lsb      = $clog2(STRB_WIDTH);
  localparam int         c_words    = 1 << (ADDR_WIDTH - c_lsb);
  localparam logic [2:0] c_max_size = 3'(c_lsb);

  localparam logic [1:0] c_burst_fixed = 2'd0;
  localparam logic [1:0] c_burst_wrap  = 2'd2;
  localparam logic [1:0] c_burst_rsvd  = 2'd3;
  localparam logic [1:0] c_resp_okay   = 2'b00;
  localparam logic [1:0] c_resp_slverr = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  state_t                  r_state;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [7:0]              r_len;
  logic [2:0]              r_size;
  logic [1:0]              r_burst;
  logic [7:0]              r_beat;
  logic                    r_err;
  logic [DATA_WIDTH-1:0]   r_mem [c_words];

  logic                    w_w_fire;
  logic                    w_last_beat;
  logic                    w_last_err;
  logic                    w_beat_err;
  logic                    w_aw_err;
  logic                    w_wrap_len_ok;
  logic [ADDR_WIDTH-1:0]   w_inc;
  logic [ADDR_WIDTH-1:0]   w_mask;
  logic [ADDR_WIDTH-1:0]   w_next_addr;
  logic [ADDR_WIDTH-c_lsb-1:0] w_word;

  // Beats are never taken while reset is asserted, so a reset edge cannot commit data.
  assign w_w_fire    = rst && (r_state == ST_WRITE) && s_axi_wready && s_axi_wvalid;
  assign w_last_beat = (r_beat == r_len);
  assign w_last_err  = (s_axi_wlast != w_last_beat);
  // A beat carrying a wlast violation is itself suppressed, not only the ones after it.
  assign w_beat_err  = r_err || w_last_err;
  assign w_word      = r_addr[ADDR_WIDTH-1:c_lsb];

  assign w_wrap_len_ok = (s_axi_awlen == 8'd1) || (s_axi_awlen == 8'd3) ||
                         (s_axi_awlen == 8'd7) || (s_axi_awlen == 8'd15);
  assign w_aw_err = (s_axi_awsize > c_max_size) ||
                    (s_axi_awburst == c_burst_rsvd) ||
                    ((s_axi_awburst == c_burst_wrap) && !w_wrap_len_ok);

  assign w_inc  = ADDR_WIDTH'(1) << r_size;
  assign w_mask = ((ADDR_WIDTH'(r_len) + ADDR_WIDTH'(1)) << r_size) - ADDR_WIDTH'(1);

  always_comb begin
    w_next_addr = r_addr + w_inc;
    if (r_burst == c_burst_fixed) begin
      w_next_addr = r_addr;
    end else if (r_burst == c_burst_wrap) begin
      w_next_addr = (r_addr & ~w_mask) | ((r_addr + w_inc) & w_mask);
    end
  end

  // Byte-enable RAM; contents survive reset.
  always_ff @(posedge clk) begin
    if (w_w_fire && !w_beat_err) begin
      for (int i = 0; i < STRB_WIDTH; i++) begin
        if (s_axi_wstrb[i]) begin
          r_mem[w_word][i*8 +: 8] <= s_axi_wdata[i*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state       <= ST_IDLE;
      r_addr        <= '0;
      r_len         <= '0;
      r_size        <= '0;
      r_burst       <= '0;
      r_beat        <= '0;
      r_err         <= 1'b0;
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bid     <= '0;
      s_axi_bresp   <= c_resp_okay;
      dbg_rdata     <= '0;
    end else begin
      dbg_rdata <= r_mem[dbg_addr];
      case (r_state)
        ST_IDLE: begin
          if (s_axi_awready && s_axi_awvalid) begin
            r_addr        <= s_axi_awaddr;
            r_len         <= s_axi_awlen;
            r_size        <= s_axi_awsize;
            r_burst       <= s_axi_awburst;
            r_beat        <= '0;
            r_err         <= w_aw_err;
            s_axi_bid     <= s_axi_awid;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b1;
            r_state       <= ST_WRITE;
          end else begin
            s_axi_awready <= 1'b1;
          end
        end
        ST_WRITE: begin
          if (w_w_fire) begin
            r_addr <= w_next_addr;
            r_beat <= r_beat + 8'd1;
            if (w_last_err) begin
              r_err <= 1'b1;
            end
            if (w_last_beat) begin
              s_axi_wready <= 1'b0;
              s_axi_bvalid <= 1'b1;
              s_axi_bresp  <= w_beat_err ? c_resp_slverr : c_resp_okay;
              r_state      <= ST_RESP;
            end
          end
        end
        ST_RESP: begin
          if (s_axi_bready) begin
            s_axi_bvalid  <= 1'b0;
            s_axi_awready <= 1'b1;
            r_state       <= ST_IDLE;
          end
        end
        default: begin
          s_axi_awready <= 1'b0;
          s_axi_wready  <= 1'b0;
          s_axi_bvalid  <= 1'b0;
          r_state       <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axi_ram_wr_responder.sv
`default_nettype none
// Randomized scoreboard bench for axi_ram_wr_responder with a byte-level RAM model.
module tb_axi_ram_wr_responder;
  localparam int DW = 32;
  localparam int AW = 16;
  localparam int SW = 4;
  localparam int IW = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [IW-1:0]   awid = '0;
  logic [AW-1:0]   awaddr = '0;
  logic [7:0]      awlen = '0;
  logic [2:0]      awsize = '0;
  logic [1:0]      awburst = '0;
  logic            awvalid = 1'b0;
  logic            awready;
  logic [DW-1:0]   wdata = '0;
  logic [SW-1:0]   wstrb = '0;
  logic            wlast = 1'b0;
  logic            wvalid = 1'b0;
  logic            wready;
  logic [IW-1:0]   bid;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready = 1'b0;
  logic [AW-3:0]   dbg_addr = '0;
  logic [DW-1:0]   dbg_rdata;

  axi_ram_wr_responder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(SW), .ID_WIDTH(IW)) dut (
    .clk(clk), .rst(rst),
    .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awsize(awsize),
    .s_axi_awburst(awburst), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast), .s_axi_wvalid(wvalid),
    .s_axi_wready(wready), .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid),
    .s_axi_bready(bready), .dbg_addr(dbg_addr), .dbg_rdata(dbg_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] id;
    logic [1:0] resp;
  } exp_t;

  int          total = 0;
  int          bad = 0;
  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [7:0]  ref_mem [1024];
  logic [31:0] beat_data [256];
  logic [3:0]  beat_strb [256];
  int          touched[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_word(input int w);
    return {ref_mem[w*4+3], ref_mem[w*4+2], ref_mem[w*4+1], ref_mem[w*4]};
  endfunction

  // Monitor: every B handshake is matched against the oldest expected response.
  always @(negedge clk) begin
    if (rst && bvalid && bready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_b: got bid %0h with no burst outstanding at %0t", bid, $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("bid", 64'(bid), 64'(mon_e.id));
        check("bresp", 64'(bresp), 64'(mon_e.resp));
      end
    end
  end

  // Reference model: burst address rules applied with plain arithmetic over a byte array.
  task automatic model_burst(input logic [7:0] id, input int addr, input int len, input int size,
                             input int burst, input int bad_last, output logic [1:0] resp);
    bit aw_err;
    bit err;
    int inc;
    int span;
    int lo;
    int a;
    int w;
    aw_err = (size > 2) || (burst == 3) ||
             (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15));
    err  = aw_err || (bad_last >= 0);
    inc  = 1 << size;
    span = (len + 1) * inc;
    lo   = (addr / span) * span;
    touched.delete();
    for (int k = 0; k <= len; k++) begin
      if (burst == 0) a = addr;
      else if (burst == 2) a = lo + ((addr - lo + k * inc) % span);
      else a = (addr + k * inc) % 65536;
      w = a >> 2;
      touched.push_back(w);
      if (!aw_err && !(bad_last >= 0 && k >= bad_last)) begin
        for (int i = 0; i < 4; i++) begin
          if (beat_strb[k][i]) ref_mem[w*4+i] = beat_data[k][i*8 +: 8];
        end
      end
    end
    resp = err ? 2'd2 : 2'd0;
    exp_q.push_back(exp_t'{id: id, resp: resp});
  endtask

  task automatic run_burst(input logic [7:0] id, input int addr, input int len, input int size,
                           input int burst, input int bad_last, input int hold_b,
                           input bit early_w, input bit chk_hold);
    logic [1:0] resp;
    int n;
    model_burst(id, addr, len, size, burst, bad_last, resp);
    fork
      begin
        awid = id; awaddr = 16'(addr); awlen = 8'(len); awsize = 3'(size);
        awburst = 2'(burst); awvalid = 1'b1;
        for (n = 0; n < 200; n++) begin
          @(negedge clk);
          if (awready) break;
        end
        if (n == 200) check("aw_timeout", 0, 1);
        @(posedge clk); #1;
        awvalid = 1'b0;
      end
      begin
        if (!early_w) repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
        for (int k = 0; k <= len; k++) begin
          if ($urandom % 4 == 0) begin
            wvalid = 1'b0;
            @(posedge clk); #1;
          end
          wdata = beat_data[k];
          wstrb = beat_strb[k];
          wlast = (k == len) ^ (k == bad_last);
          wvalid = 1'b1;
          for (n = 0; n < 200; n++) begin
            @(negedge clk);
            if (wready) break;
          end
          if (n == 200) check("w_timeout", 0, 1);
          if (k == len) check("bvalid_during_last", 64'(bvalid), 0);
          @(posedge clk); #1;
          if (k == len) check("bvalid_after_last", 64'(bvalid), 1);
        end
        wvalid = 1'b0;
        wlast = 1'b0;
      end
    join
    for (int c = 0; c < hold_b; c++) begin
      @(negedge clk);
      if (chk_hold) begin
        check("hold_bvalid", 64'(bvalid), 1);
        check("hold_bid", 64'(bid), 64'(id));
        check("hold_bresp", 64'(bresp), 64'(resp));
        check("hold_awready", 64'(awready), 0);
      end
      @(posedge clk); #1;
    end
    bready = 1'b1;
    for (n = 0; n < 200; n++) begin
      @(negedge clk);
      if (bvalid) break;
    end
    if (n == 200) check("b_timeout", 0, 1);
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  task automatic dbg_check(input int w);
    dbg_addr = 14'(w);
    @(posedge clk); #1;
    check("dbg_word", 64'(dbg_rdata), 64'(ref_word(w)));
  endtask

  task automatic check_touched();
    int tw[$];
    tw = touched;
    foreach (tw[j]) dbg_check(tw[j]);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int burst, size, len, addr, bad_last;
    logic [31:0] word_c;
    for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_awready", 64'(awready), 0);
    check("rst_wready", 64'(wready), 0);
    check("rst_bvalid", 64'(bvalid), 0);
    check("rst_bid", 64'(bid), 0);
    check("rst_bresp", 64'(bresp), 0);
    check("rst_dbg_rdata", 64'(dbg_rdata), 0);
    rst = 1'b1;
    check("rel_awready_first", 64'(awready), 0);
    @(posedge clk); #1;
    check("rel_awready_second", 64'(awready), 1);

    // Zero-fill the working region so model and RAM start identical
    for (int k = 0; k < 256; k++) begin beat_data[k] = 32'h0; beat_strb[k] = 4'hF; end
    run_burst(8'h01, 0, 255, 2, 1, -1, 0, 1'b0, 1'b0);

    // INCR
    for (int k = 0; k < 4; k++) begin beat_data[k] = 32'h11111111 * (k + 1); beat_strb[k] = 4'hF; end
    run_burst(8'h5A, 16'h0010, 3, 2, 1, -1, 1, 1'b1, 1'b0);
    check_touched();
    dbg_check(7);
    check("incr_word7_const", 64'(dbg_rdata), 64'h44444444);

    // WRAP across a 16-byte boundary
    for (int k = 0; k < 4; k++) begin beat_data[k] = 32'hA0000000 + k; beat_strb[k] = 4'hF; end
    run_burst(8'h21, 16'h0038, 3, 2, 2, -1, 0, 1'b0, 1'b0);
    check_touched();
    dbg_check(12);
    check("wrap_word_0x30_const", 64'(dbg_rdata), 64'hA0000002);

    // FIXED with walking strobes
    beat_data[0] = 32'h000000AA; beat_strb[0] = 4'h1;
    beat_data[1] = 32'h0000BB00; beat_strb[1] = 4'h2;
    beat_data[2] = 32'h00CC0000; beat_strb[2] = 4'h4;
    run_burst(8'h33, 16'h0100, 2, 2, 0, -1, 2, 1'b0, 1'b0);
    dbg_check(16'h40);
    word_c = 32'h00CCBBAA;
    check("fixed_word_const", 64'(dbg_rdata), 64'(word_c));

    // Error bursts: oversized beat, reserved burst, early wlast
    for (int k = 0; k < 4; k++) begin beat_data[k] = 32'hDEAD0000 + k; beat_strb[k] = 4'hF; end
    run_burst(8'h41, 16'h0080, 3, 3, 1, -1, 0, 1'b0, 1'b0);
    check_touched();
    run_burst(8'h42, 16'h0090, 3, 2, 3, -1, 0, 1'b1, 1'b0);
    check_touched();
    run_burst(8'h43, 16'h00A0, 3, 2, 1, 0, 0, 1'b0, 1'b0);
    check_touched();

    // Back-pressured response
    for (int k = 0; k < 2; k++) begin beat_data[k] = $urandom; beat_strb[k] = 4'hF; end
    run_burst(8'h77, 16'h00C0, 1, 2, 1, -1, 10, 1'b0, 1'b1);

    // Reset in the middle of a burst
    awid = 8'h99; awaddr = 16'h0200; awlen = 8'd3; awsize = 3'd2; awburst = 2'd1; awvalid = 1'b1;
    for (int n = 0; n < 50; n++) begin @(negedge clk); if (awready) break; end
    @(posedge clk); #1;
    awvalid = 1'b0;
    wdata = 32'hCAFEF00D; wstrb = 4'hF; wlast = 1'b0; wvalid = 1'b1;
    for (int n = 0; n < 50; n++) begin @(negedge clk); if (wready) break; end
    @(posedge clk); #1;
    wvalid = 1'b0;
    for (int i = 0; i < 4; i++) ref_mem[16'h200 + i] = wdata[i*8 +: 8];
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check("midrst_awready", 64'(awready), 0);
      check("midrst_wready", 64'(wready), 0);
      check("midrst_bvalid", 64'(bvalid), 0);
    end
    rst = 1'b1;
    check("midrel_awready_first", 64'(awready), 0);
    @(posedge clk); #1;
    check("midrel_awready_second", 64'(awready), 1);
    dbg_check(16'h80);
    dbg_check(16'h81);

    // Randomized bursts
    for (int t = 0; t < 40; t++) begin
      case ($urandom % 16)
        0, 1, 2, 3: burst = 0;
        4, 5, 6, 7, 8: burst = 1;
        15: burst = 3;
        default: burst = 2;
      endcase
      size = ($urandom % 8 == 0) ? 3 : int'($urandom % 3);
      if (burst == 2 && $urandom % 6 != 0) begin
        case ($urandom % 4)
          0: len = 1;
          1: len = 3;
          2: len = 7;
          default: len = 15;
        endcase
      end else begin
        len = int'($urandom % 16);
      end
      addr = int'($urandom % 768);
      bad_last = (len > 0 && $urandom % 8 == 0) ? 0 : -1;
      for (int k = 0; k <= len; k++) begin
        beat_data[k] = $urandom;
        beat_strb[k] = 4'($urandom);
      end
      run_burst(8'($urandom), addr, len, size, burst, bad_last, int'($urandom % 4),
                1'($urandom), 1'b0);
      check_touched();
    end

    repeat (5) @(posedge clk);
    #1;
    check("pending_b", 64'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
